// File: rtl/irrigation_timer_ctrl_pkg.sv
// rtl/irrigation_timer_ctrl_pkg.sv - shared state encodings, digit limits and preset clamp helper
package irrigation_timer_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] UNITS_MAX    = 4'd9;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
  } mmss_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Out-of-range BCD digits from the panel are saturated, never wrapped.
  function automatic mmss_t clamp_preset(input logic [7:0] mn, input logic [7:0] sc);
    mmss_t r;
    r.min_t = clamp_digit(mn[7:4], SEC_TENS_MAX);
    r.min_u = clamp_digit(mn[3:0], UNITS_MAX);
    r.sec_t = clamp_digit(sc[7:4], SEC_TENS_MAX);
    r.sec_u = clamp_digit(sc[3:0], UNITS_MAX);
    return r;
  endfunction

endpackage

// File: rtl/irrigation_timer_ctrl_bcd_down_digit.sv
// rtl/irrigation_timer_ctrl_bcd_down_digit.sv - one loadable BCD down-counter digit with borrow out
module bcd_down_digit
  import irrigation_timer_ctrl_pkg::*;
#(
  parameter logic [3:0] MAX = UNITS_MAX
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] q,
  output logic       borrow
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign borrow = dec & (q_q == 4'd0);

endmodule

// File: rtl/irrigation_timer_ctrl.sv
// rtl/irrigation_timer_ctrl.sv - watering-cycle FSM and 1 s prescaler; SOIL_SENSOR_EN adds soil_wet early stop
module irrigation_timer_ctrl
  import irrigation_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
`ifdef SOIL_SENSOR_EN
  input  logic       soil_wet,
`endif
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic       valve,
  output logic       busy,
  output logic       done,
  output logic [7:0] count_min,
  output logic [7:0] count_sec,
  output logic [2:0] state_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          wet;
  logic          tick;
  logic          load;
  mmss_t         load_val;
  mmss_t         cnt;
  logic          borrow_su, borrow_st, borrow_mu, borrow_mt;

`ifdef SOIL_SENSOR_EN
  assign wet = soil_wet;
`else
  assign wet = 1'b0;
`endif

  // Sensor and stop both suppress the tick so the count freezes on that edge.
  assign tick = (state_q == ST_RUN) && !wet && !stop && (pre_q == PRE_LAST);

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (start && !wet && ((preset_min | preset_sec) != 8'h00)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load     = 1'b1;
        load_val = clamp_preset(preset_min, preset_sec);
        pre_d    = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (wet) begin
          state_d = ST_DONE;
        end else if (stop) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          pre_d = '0;
          // A borrow out of the top digit would mean underflow; end the cycle either way.
          if (cnt == 16'h0001 || borrow_mt) state_d = ST_DONE;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          pre_d   = '0;
        end else if (stop && !start) begin
          state_d = ST_IDLE;
          load    = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
    end
  end

  bcd_down_digit #(.MAX(UNITS_MAX)) u_sec_u (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val.sec_u),
    .dec(tick), .q(cnt.sec_u), .borrow(borrow_su)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_t (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val.sec_t),
    .dec(borrow_su), .q(cnt.sec_t), .borrow(borrow_st)
  );

  bcd_down_digit #(.MAX(UNITS_MAX)) u_min_u (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val.min_u),
    .dec(borrow_st), .q(cnt.min_u), .borrow(borrow_mu)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_min_t (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val.min_t),
    .dec(borrow_mu), .q(cnt.min_t), .borrow(borrow_mt)
  );

  assign valve     = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign count_min = {cnt.min_t, cnt.min_u};
  assign count_sec = {cnt.sec_t, cnt.sec_u};
  assign state_o   = state_q;

endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
// tb/tb_irrigation_timer_ctrl.sv - scoreboard bench for irrigation_timer_ctrl, optional SOIL_SENSOR_EN scenario
module tb_irrigation_timer_ctrl;

  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset, start, stop;
  logic [7:0] preset_min, preset_sec;
  logic       valve, busy, done;
  logic [7:0] count_min, count_sec;
  logic [2:0] state_o;
`ifdef SOIL_SENSOR_EN
  logic       soil_wet;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] prev_cnt;
  logic [15:0] sb_exp;
  bit          mon_en = 1'b0;

  irrigation_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .stop(stop),
`ifdef SOIL_SENSOR_EN
    .soil_wet(soil_wet),
`endif
    .preset_min(preset_min),
    .preset_sec(preset_sec),
    .valve(valve),
    .busy(busy),
    .done(done),
    .count_min(count_min),
    .count_sec(count_sec),
    .state_o(state_o)
  );

  always #5 clock = ~clock;

  function automatic int to_secs(input logic [15:0] v);
    return int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] from_secs(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  function automatic logic [3:0] sat(input logic [3:0] d, input int lim);
    return (int'(d) > lim) ? 4'(lim) : d;
  endfunction

  function automatic logic [15:0] clamp_model(input logic [7:0] mn, input logic [7:0] sc);
    return {sat(mn[7:4], 5), sat(mn[3:0], 9), sat(sc[7:4], 5), sat(sc[3:0], 9)};
  endfunction

  // Expected visible count after every tick from (from-1) down to and including 'to'.
  task automatic push_countdown(input logic [15:0] from, input logic [15:0] to);
    for (int s = to_secs(from) - 1; s >= to_secs(to); s--) exp_q.push_back(from_secs(s));
  endtask

  always @(negedge clock) begin
    if (mon_en && ({count_min, count_sec} !== prev_cnt)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_count: got %h, no change expected", {count_min, count_sec});
      end else begin
        sb_exp = exp_q.pop_front();
        if ({count_min, count_sec} !== sb_exp) begin
          failures++;
          $display("FAIL sb_count: got %h, expected %h", {count_min, count_sec}, sb_exp);
        end
      end
    end
    prev_cnt = {count_min, count_sec};
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start(input logic [7:0] mn, input logic [7:0] sc);
    preset_min = mn;
    preset_sec = sc;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_count(input logic [15:0] v, input int budget, input string nm);
    int n = 0;
    while ({count_min, count_sec} !== v && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if ({count_min, count_sec} !== v) begin
      failures++;
      $display("FAIL %s: count %h, expected %h within %0d cycles", nm, {count_min, count_sec}, v, budget);
    end
  endtask

  task automatic wait_done(input int budget, output int run_cyc, output int valve_lat, output bit ok);
    run_cyc = 0;
    valve_lat = -1;
    ok = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      cyc(1);
      if (valve === 1'b1 && valve_lat < 0) valve_lat = n;
      if (state_o === 3'd2) run_cyc++;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_sb_empty(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_sb_empty: %0d expected values left, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_cleared(input string nm);
    checks++;
    if (valve !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        {count_min, count_sec} !== 16'h0000 || state_o !== 3'd0) begin
      failures++;
      $display("FAIL %s: valve=%b busy=%b done=%b count=%h state=%0d, required 0 0 0 0000 0",
               nm, valve, busy, done, {count_min, count_sec}, state_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    preset_min = 8'h00;
    preset_sec = 8'h00;
`ifdef SOIL_SENSOR_EN
    soil_wet = 1'b0;
`endif
    cyc(1);
    reset = 1'b0;
    check_idle_cleared("reset_state");
    cyc(1);
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int rc, vl;
    bit ok;
    exp_q.push_back(16'h0003);
    push_countdown(16'h0003, 16'h0000);
    pulse_start(8'h00, 8'h03);
    checks++;
    if (valve !== 1'b0 || state_o !== 3'd1) begin
      failures++;
      $display("FAIL basic_load: valve=%b state=%0d, required 0 1", valve, state_o);
    end
    wait_done(60, rc, vl, ok);
    checks++;
    if (!ok || rc != 3 * TD || vl != 1) begin
      failures++;
      $display("FAIL basic_run: done=%b run_cycles=%0d valve_lat=%0d, required 1 %0d 1", ok, rc, vl, 3 * TD);
    end
    checks++;
    if (valve !== 1'b0 || {count_min, count_sec} !== 16'h0000) begin
      failures++;
      $display("FAIL basic_done: valve=%b count=%h, required 0 0000", valve, {count_min, count_sec});
    end
    cyc(1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_after: done=%b busy=%b, required 0 0", done, busy);
    end
    check_sb_empty("basic");
  endtask

  task automatic test_borrow();
    int rc, vl;
    bit ok;
    exp_q.push_back(16'h0100);
    push_countdown(16'h0100, 16'h0000);
    pulse_start(8'h01, 8'h00);
    wait_done(400, rc, vl, ok);
    checks++;
    if (!ok || rc != 60 * TD) begin
      failures++;
      $display("FAIL borrow_run: done=%b run_cycles=%0d, required 1 %0d", ok, rc, 60 * TD);
    end
    cyc(1);
    check_sb_empty("borrow");
  endtask

  task automatic test_pause_abort();
    bit done_seen = 1'b0;
    exp_q.push_back(16'h0005);
    push_countdown(16'h0005, 16'h0003);
    pulse_start(8'h00, 8'h05);
    wait_count(16'h0003, 80, "pause_reach");
    cyc(TD - 1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    checks++;
    if (state_o !== 3'd3 || valve !== 1'b0 || {count_min, count_sec} !== 16'h0003) begin
      failures++;
      $display("FAIL pause_stop: state=%0d valve=%b count=%h, required 3 0 0003", state_o, valve, {count_min, count_sec});
    end
    cyc(5);
    checks++;
    if (state_o !== 3'd3 || {count_min, count_sec} !== 16'h0003) begin
      failures++;
      $display("FAIL pause_hold: state=%0d count=%h, required 3 0003", state_o, {count_min, count_sec});
    end
    exp_q.push_back(16'h0002);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(TD - 1);
    checks++;
    if (state_o !== 3'd2 || {count_min, count_sec} !== 16'h0003) begin
      failures++;
      $display("FAIL resume_early: state=%0d count=%h, required 2 0003", state_o, {count_min, count_sec});
    end
    cyc(1);
    checks++;
    if ({count_min, count_sec} !== 16'h0002) begin
      failures++;
      $display("FAIL resume_tick: count=%h, required 0002", {count_min, count_sec});
    end
    stop = 1'b1;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (state_o !== 3'd3) begin
      failures++;
      $display("FAIL pause_both: state=%0d, required 3", state_o);
    end
    exp_q.push_back(16'h0000);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check_idle_cleared("abort");
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (done === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen || state_o !== 3'd0) begin
      failures++;
      $display("FAIL abort_quiet: done_seen=%b state=%0d, required 0 0", done_seen, state_o);
    end
    check_sb_empty("pause");
  endtask

  task automatic test_zero_preset();
    bit valve_seen = 1'b0;
    bit busy_seen = 1'b0;
    pulse_start(8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (valve === 1'b1) valve_seen = 1'b1;
      if (busy !== 1'b0) busy_seen = 1'b1;
      cyc(1);
    end
    checks++;
    if (valve_seen || busy_seen) begin
      failures++;
      $display("FAIL zero_preset: valve_seen=%b busy_seen=%b, required 0 0", valve_seen, busy_seen);
    end
  endtask

  task automatic test_clamp_reset();
    exp_q.push_back(clamp_model(8'h7C, 8'h9F));
    exp_q.push_back(16'h5958);
    pulse_start(8'h7C, 8'h9F);
    wait_count(16'h5958, 20, "clamp_tick");
    cyc(2);
    checks++;
    if (valve !== 1'b1) begin
      failures++;
      $display("FAIL clamp_run: valve=%b, required 1", valve);
    end
    exp_q.push_back(16'h0000);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check_idle_cleared("mid_run_reset");
    cyc(3 * TD);
    check_idle_cleared("after_reset");
    check_sb_empty("clamp");
  endtask

`ifdef SOIL_SENSOR_EN
  task automatic test_soil();
    bit left_idle = 1'b0;
    exp_q.push_back(16'h0010);
    push_countdown(16'h0010, 16'h0006);
    pulse_start(8'h00, 8'h10);
    wait_count(16'h0006, 80, "soil_reach");
    soil_wet = 1'b1;
    cyc(1);
    checks++;
    if (done !== 1'b1 || state_o !== 3'd4 || valve !== 1'b0 || {count_min, count_sec} !== 16'h0006) begin
      failures++;
      $display("FAIL soil_done: done=%b state=%0d valve=%b count=%h, required 1 4 0 0006",
               done, state_o, valve, {count_min, count_sec});
    end
    cyc(1);
    checks++;
    if (done !== 1'b0 || state_o !== 3'd0 || {count_min, count_sec} !== 16'h0006) begin
      failures++;
      $display("FAIL soil_idle: done=%b state=%0d count=%h, required 0 0 0006", done, state_o, {count_min, count_sec});
    end
    pulse_start(8'h00, 8'h05);
    for (int i = 0; i < 6; i++) begin
      if (state_o !== 3'd0) left_idle = 1'b1;
      cyc(1);
    end
    soil_wet = 1'b0;
    checks++;
    if (left_idle) begin
      failures++;
      $display("FAIL soil_block_start: left IDLE while wet, required stay IDLE");
    end
    check_sb_empty("soil");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_pause_abort();
    test_zero_preset();
    test_clamp_reset();
`ifdef SOIL_SENSOR_EN
    test_soil();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
